imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Byte-stream program loader that writes the instruction memory read by the pipeline's fetch stage, then releases the CPU. It replaces the simulation-only hex preload with a hardware path: a byte source (UART receiver or bench driver) streams a length header and program words. The loader assembles big-endian 32-bit words and writes them to consecutive word addresses, holding the pipeline stalled until the load completes.

Parameters:
DEPTH, 256, instruction memory depth in 32-bit words
AW, 8, word address width; must satisfy 2**AW >= DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a load; sampled in IDLE, DONE, ERR
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte this cycle
imem_we  out  1  instruction memory write strobe, one cycle per word
imem_addr  out  AW  word address for write
imem_wdata  out  32  assembled instruction word
cpu_hold  out  1  hold pipeline in reset/stall while high
done  out  1  load completed, level
error  out  1  header length exceeded DEPTH, level
words_loaded  out  16  count of words written this load

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on rst.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, state=IDLE.
- Byte transfer occurs on a rising edge where in_valid && in_ready. in_valid with in_ready low is ignored; no buffering, so the source must hold the byte until accepted.
- States: IDLE, HDR_HI, HDR_LO, DATA, FLUSH, DONE, ERR.
- IDLE: in_ready=0. start=1 -> HDR_HI next cycle and clears words_loaded, byte counter, and word index.
- HDR_HI: in_ready=1. The accepted byte is the length N[15:8] -> HDR_LO.
- HDR_LO: in_ready=1. The accepted byte is N[7:0].
  - N==0 -> DONE.
  - N>DEPTH -> ERR.
  - Otherwise -> DATA.
- DATA: in_ready=1. Bytes are big-endian; the first byte of each word goes to bits [31:24]. On acceptance of the 4th byte:
  - Next cycle: imem_we=1, imem_addr=word index, imem_wdata=assembled word. Write latency is exactly 1 cycle after the 4th byte.
  - Word index increments and words_loaded increments in that same write cycle.
  - When the write is for word N-1 -> FLUSH.
  - in_ready stays 1 during the write cycle, so back-to-back words stream at full rate.
- FLUSH: one cycle, in_ready=0, so the last write retires -> DONE.
- DONE: done=1, cpu_hold=0, in_ready=0. Later bytes are not accepted. start=1 -> HDR_HI with cpu_hold=1 and done=0 on the next cycle.
- ERR: error=1, cpu_hold=1, in_ready=0; no writes. start=1 -> HDR_HI and clears error.
- start is ignored in HDR_HI, HDR_LO, DATA, and FLUSH.
- cpu_hold is deasserted only in DONE.
- The word index wraps never, because N is bounded by DEPTH. imem_addr is the word index truncated to AW bits.
- Reset mid-load returns to IDLE with reset values. Words already written stay in memory, and the memory is not cleared.
- A partial word at reset is discarded.
- rst has priority over start in the same cycle.

Decomposition:
- Shared package holds:
  - the state encoding (7 states, 3 bits);
  - the header byte count constant HDR_BYTES=2;
  - the word byte count BYTES_PER_WORD=4.
- One natural sub-module, byte_packer: a 4-byte shift register plus 2-bit byte counter that outputs word and word_valid. The FSM lives in imem_loader.

Test Plan:
- Two-word load. Stream 00 02, 24 08 00 05, 20 09 00 03 with continuous valid.
  - Writes at addr 0 = 0x24080005 and addr 1 = 0x20090003, each 1 cycle after its 4th byte.
  - words_loaded=2, then done=1 and cpu_hold=0 two cycles after the last byte.
- Empty program. Header 00 00 -> DONE the cycle after the low byte, no imem_we pulses, words_loaded=0.
- Oversize. Header 01 01 with DEPTH=256 -> error=1, cpu_hold=1, in_ready=0.
  - Following bytes are not accepted and no writes occur.
  - start then returns to HDR_HI with error=0.
- Throttled source. Three-word load with in_valid toggling randomly.
  - Writes land at addr 0..2 with exact big-endian words.
  - No byte is lost or duplicated; bytes presented while in_ready=0 are never consumed.
- Reset mid-load. rst asserted after word 1 and 2 bytes of word 2.
  - Next cycle all outputs are at reset values and the partial word is discarded.
  - A fresh start plus a 1-word load writes addr 0.
- Reload after DONE. start in DONE gives cpu_hold=1 and done=0 next cycle.
  - A second 1-word load overwrites addr 0; words_loaded restarts at 0, then reaches 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t        : loader FSM state encoding (7 states, 3 bits)
//   HDR_BYTES      : length header size in bytes (big-endian word count)
//   BYTES_PER_WORD : bytes assembled into one 32-bit instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer.
// The first three bytes of a word are held in a shift register.
// The fourth byte is merged combinationally, so word/word_valid appear in
// the same cycle that byte is accepted. The loader registers them on that
// edge, which gives a write exactly one cycle after the 4th byte.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop any partial word (new load)
//   byte_en    : byte_data is accepted this cycle
//   byte_data  : stream byte
//   word       : assembled word, first byte in [31:24]
//   word_valid : byte_en on the last byte of a word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [23:0]   sr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (byte_en) begin
      sr  <= {sr[15:0], byte_data};
      cnt <= cnt + 1'b1;
    end
  end

  assign word       = {sr, byte_data};
  assign word_valid = byte_en && (cnt == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader.
// Receives a big-endian word count, then that many big-endian 32-bit words.
// Each word is written to consecutive imem addresses from 0. The CPU is
// held until the load completes.
//
//   state    | meaning
//   IDLE     | after reset, waiting for start
//   HDR_HI   | accepting length byte N[15:8]
//   HDR_LO   | accepting length byte N[7:0], range check
//   DATA     | accepting program bytes, writing words
//   FLUSH    | last write in flight, stream closed
//   DONE     | load complete, CPU released
//   ERR      | length exceeded DEPTH, CPU held
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a load (honoured in IDLE/DONE/ERR)
//   in_data/in_valid      : byte stream in
//   in_ready              : byte accepted when in_valid && in_ready
//   imem_we/addr/wdata    : instruction memory write port
//   cpu_hold              : pipeline hold, low only in DONE
//   done, error           : status levels
//   words_loaded          : words written during the current load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);

  state_t                   state;
  logic [7:0]               hdr_hi;
  logic [8*HDR_BYTES-1:0]   n_words;
  logic [8*HDR_BYTES-1:0]   hdr_len;
  logic                     accept;
  logic                     can_start;
  logic [31:0]              pk_word;
  logic                     pk_valid;

  assign accept    = in_valid && in_ready;
  assign hdr_len   = {hdr_hi, in_data};
  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start && can_start),
    .byte_en    (accept && (state == S_DATA)),
    .byte_data  (in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      hdr_hi       <= '0;
      n_words      <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_HDR_HI;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            hdr_hi <= in_data;
            state  <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            n_words <= hdr_len;
            if (hdr_len == '0) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (32'(hdr_len) > DEPTH) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // in_ready stays high through a write so words stream back to back.
          if (pk_valid) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[AW-1:0];
            imem_wdata   <= pk_word;
            words_loaded <= words_loaded + 16'd1;
            if (words_loaded == n_words - 16'd1) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          state    <= S_DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: memory model fed by imem_we, inline checks.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  logic [31:0] mem [0:255];

  imem_loader #(.DEPTH(256), .AW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      wr_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b exp=1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Streams one word and checks the write that must follow its last byte.
  task automatic send_word(input logic [31:0] w, input int max_gap,
                           input logic [7:0] exp_addr, input logic [15:0] exp_loaded,
                           input logic exp_ready);
    for (int i = 3; i >= 0; i--)
      send_byte(w[8*i +: 8], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
    checks++;
    if (imem_we !== 1'b1) begin failures++; $display("FAIL wr_strobe got=%b exp=1 word=%h", imem_we, w); end
    checks++;
    if (imem_addr !== exp_addr) begin failures++; $display("FAIL wr_addr got=%h exp=%h", imem_addr, exp_addr); end
    checks++;
    if (imem_wdata !== w) begin failures++; $display("FAIL wr_data got=%h exp=%h", imem_wdata, w); end
    checks++;
    if (words_loaded !== exp_loaded) begin failures++; $display("FAIL wr_words_loaded got=%0d exp=%0d", words_loaded, exp_loaded); end
    checks++;
    if (in_ready !== exp_ready) begin failures++; $display("FAIL wr_in_ready got=%b exp=%b", in_ready, exp_ready); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL wr_done got=%b exp=0", done); end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    checks++;
    if ({in_ready, imem_we, cpu_hold, done, error} !== 5'b00100) begin
      failures++; $display("FAIL reset_flags got=%b exp=00100", {in_ready, imem_we, cpu_hold, done, error});
    end
    checks++;
    if (imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      failures++; $display("FAIL reset_wport got=%h/%h exp=00/00000000", imem_addr, imem_wdata);
    end
    checks++;
    if (words_loaded !== 16'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL idle_hold in_ready=%b cpu_hold=%b exp 0/1", in_ready, cpu_hold);
    end
  endtask

  task automatic test_two_word();
    int w0;
    w0 = wr_count;
    do_start();
    checks++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL start_hdr in_ready=%b cpu_hold=%b exp 1/1", in_ready, cpu_hold);
    end
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h24080005, 0, 8'd0, 16'd1, 1'b1);
    send_word(32'h20090003, 0, 8'd1, 16'd2, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL two_done done=%b cpu_hold=%b exp 1/0", done, cpu_hold);
    end
    checks++;
    if (words_loaded !== 16'd2) begin failures++; $display("FAIL two_words got=%0d exp=2", words_loaded); end
    checks++;
    if (mem[0] !== 32'h24080005 || mem[1] !== 32'h20090003) begin
      failures++; $display("FAIL two_mem got=%h,%h exp=24080005,20090003", mem[0], mem[1]);
    end
    checks++;
    if (wr_count - w0 !== 2) begin failures++; $display("FAIL two_wr_count got=%0d exp=2", wr_count - w0); end
    // DONE ignores the stream
    in_data = 8'h77; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b1 || wr_count - w0 !== 2) begin
      failures++; $display("FAIL done_ignore in_ready=%b done=%b writes=%0d exp 0/1/2", in_ready, done, wr_count - w0);
    end
  endtask

  task automatic test_empty();
    int w0;
    w0 = wr_count;
    do_start();
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL empty_start done=%b cpu_hold=%b exp 0/1", done, cpu_hold);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL empty_done done=%b cpu_hold=%b in_ready=%b exp 1/0/0", done, cpu_hold, in_ready);
    end
    checks++;
    if (words_loaded !== 16'd0 || wr_count != w0) begin
      failures++; $display("FAIL empty_nowrite words=%0d writes=%0d exp 0/0", words_loaded, wr_count - w0);
    end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = wr_count;
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL over_err error=%b cpu_hold=%b in_ready=%b done=%b exp 1/1/0/0", error, cpu_hold, in_ready, done);
    end
    in_data = 8'hAA; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || error !== 1'b1 || wr_count != w0) begin
      failures++; $display("FAIL over_ignore in_ready=%b error=%b writes=%0d exp 0/1/0", in_ready, error, wr_count - w0);
    end
    do_start();
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL over_restart error=%b in_ready=%b cpu_hold=%b exp 0/1/1", error, in_ready, cpu_hold);
    end
    // Boundary: N == DEPTH is legal; abandon it via reset afterwards.
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL depth_ok error=%b in_ready=%b exp 0/1", error, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_throttled();
    int w0;
    w0 = wr_count;
    do_start();
    send_byte(8'h00, 2);
    send_byte(8'h03, 1);
    send_word(32'h11223344, 3, 8'd0, 16'd1, 1'b1);
    send_word(32'hA5B6C7D8, 3, 8'd1, 16'd2, 1'b1);
    send_word(32'hDEADBEEF, 3, 8'd2, 16'd3, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || words_loaded !== 16'd3 || wr_count - w0 !== 3) begin
      failures++; $display("FAIL thr_done done=%b words=%0d writes=%0d exp 1/3/3", done, words_loaded, wr_count - w0);
    end
    checks++;
    if (mem[0] !== 32'h11223344 || mem[1] !== 32'hA5B6C7D8 || mem[2] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL thr_mem got=%h,%h,%h exp=11223344,a5b6c7d8,deadbeef", mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_reset_midload();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'hCAFEF00D, 0, 8'd0, 16'd1, 1'b1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, imem_we, cpu_hold, done, error} !== 5'b00100) begin
      failures++; $display("FAIL mid_rst_flags got=%b exp=00100", {in_ready, imem_we, cpu_hold, done, error});
    end
    checks++;
    if (imem_addr !== 8'h00 || imem_wdata !== 32'h0 || words_loaded !== 16'd0) begin
      failures++; $display("FAIL mid_rst_regs got=%h/%h/%0d exp=00/00000000/0", imem_addr, imem_wdata, words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h55667788, 0, 8'd0, 16'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem[0] !== 32'h55667788) begin
      failures++; $display("FAIL mid_reload done=%b mem0=%h exp 1/55667788", done, mem[0]);
    end
  endtask

  task automatic test_reload();
    do_start();
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || words_loaded !== 16'd0) begin
      failures++; $display("FAIL reload_start cpu_hold=%b done=%b words=%0d exp 1/0/0", cpu_hold, done, words_loaded);
    end
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h99AABBCC, 0, 8'd0, 16'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 16'd1 || mem[0] !== 32'h99AABBCC) begin
      failures++; $display("FAIL reload_done done=%b cpu_hold=%b words=%0d mem0=%h exp 1/0/1/99aabbcc",
                           done, cpu_hold, words_loaded, mem[0]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_two_word();
    test_empty();
    test_oversize();
    test_throttled();
    test_reset_midload();
    test_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
